// File: rtl/video_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_capture_pkg
// Description : Shared types and helpers for the video capture decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package video_capture_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_LOCKED  = 2'd3
    } cap_state_e;

    localparam int DEFAULT_POS_WIDTH = 10;
    localparam int DEFAULT_CNT_WIDTH = 12;

    // Maps a raw sync pin onto "1 = pulse active" regardless of panel polarity.
    function automatic logic normalize_sync(input logic raw, input logic active_low);
        return raw ^ active_low;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : video_edge_detect
// Description : Registers a small bundle of level signals and emits per-bit
//               leading or falling edge strobes plus the MSB's current level.
// Revision    : 1.0 - initial release
// ============================================================================
module video_edge_detect #(
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] FALL_MASK = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] event_o,
    output logic             msb_level_o
);

    logic [WIDTH-1:0] cur_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            cur_q  <= sig_i;
            prev_q <= cur_q;
        end
    end

    // Bits selected by FALL_MASK report falling edges, the rest leading edges.
    assign event_o     = (FALL_MASK & ~cur_q & prev_q) | (~FALL_MASK & cur_q & ~prev_q);
    assign msb_level_o = cur_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/video_capture_decoder.sv
`default_nettype none
// ============================================================================
// Module      : video_capture_decoder
// Description : Parallel RGB receiver: recovers x/y, measures frame geometry,
//               locks after two matching frames and emits a qualified stream.
// Revision    : 1.0 - initial release
// ============================================================================
module video_capture_decoder
    import video_capture_pkg::*;
#(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int POS_WIDTH       = DEFAULT_POS_WIDTH,
    parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
    input  logic                 disp_clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 in_hsync,
    input  logic                 in_vsync,
    input  logic                 in_de,
    input  logic [7:0]           in_red,
    input  logic [7:0]           in_green,
    input  logic [7:0]           in_blue,
    output logic                 pix_valid,
    output logic [POS_WIDTH-1:0] pix_x,
    output logic [POS_WIDTH-1:0] pix_y,
    output logic [7:0]           pix_red,
    output logic [7:0]           pix_green,
    output logic [7:0]           pix_blue,
    output logic                 pix_sof,
    output logic                 pix_eol,
    output logic                 locked,
    output logic [POS_WIDTH-1:0] frame_width,
    output logic [POS_WIDTH-1:0] frame_height,
    output logic [CNT_WIDTH-1:0] line_total,
    output logic                 error
);

    localparam logic [POS_WIDTH-1:0] POS_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [2:0] sync_norm;
    logic [2:0] sync_evt;
    logic       de_s1;
    logic       hs_lead, vs_lead, de_fall;

    assign sync_norm = {in_de,
                        normalize_sync(in_vsync, SYNC_ACTIVE_LOW),
                        normalize_sync(in_hsync, SYNC_ACTIVE_LOW)};

    video_edge_detect #(
        .WIDTH     (3),
        .FALL_MASK (3'b100)
    ) u_edge (
        .clk_i       (disp_clk),
        .rst_i       (reset),
        .sig_i       (sync_norm),
        .event_o     (sync_evt),
        .msb_level_o (de_s1)
    );

    assign hs_lead = sync_evt[0];
    assign vs_lead = sync_evt[1];
    assign de_fall = sync_evt[2];

    cap_state_e           state_q;
    logic [POS_WIDTH-1:0] x_cnt_q, y_cnt_q, last_w_q, cand_w_q, cand_h_q;
    logic [CNT_WIDTH-1:0] line_clk_q, last_lt_q, cand_lt_q;
    logic [23:0]          rgb_s1_q, pix_rgb_q;
    logic [POS_WIDTH-1:0] pix_x_q, pix_y_q;
    logic                 pix_valid_q, pix_sof_q, pix_eol_q, error_q;

    logic [POS_WIDTH-1:0] x_now, y_now, meas_w, meas_h;
    logic [CNT_WIDTH-1:0] meas_lt;
    logic                 geom_ok, sat, violation, load_cand, valid_d;

    // A DE fall coincident with the vsync edge still belongs to the ending frame.
    always_comb begin
        x_now     = hs_lead ? '0 : x_cnt_q;
        y_now     = vs_lead ? '0 : y_cnt_q;
        meas_w    = de_fall ? x_cnt_q : last_w_q;
        meas_h    = (de_fall && (y_cnt_q != POS_MAX)) ? y_cnt_q + POS_WIDTH'(1) : y_cnt_q;
        meas_lt   = hs_lead ? line_clk_q : last_lt_q;
        geom_ok   = (meas_w == cand_w_q) && (meas_h == cand_h_q) && (meas_lt == cand_lt_q);
        sat       = (x_cnt_q == POS_MAX) || (y_cnt_q == POS_MAX) || (line_clk_q == CNT_MAX);
        violation = (vs_lead && !geom_ok) ||
                    (de_fall && (x_cnt_q != cand_w_q)) ||
                    (hs_lead && (line_clk_q != cand_lt_q)) ||
                    sat;
        load_cand = en && (((state_q == ST_MEASURE) && vs_lead) ||
                           ((state_q == ST_VERIFY) && vs_lead && !geom_ok) ||
                           ((state_q == ST_LOCKED) && violation));
        valid_d   = en && (state_q == ST_LOCKED) && !violation && de_s1;
    end

    always_ff @(posedge disp_clk) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            line_clk_q  <= '0;
            last_w_q    <= '0;
            last_lt_q   <= '0;
            cand_w_q    <= '0;
            cand_h_q    <= '0;
            cand_lt_q   <= '0;
            error_q     <= 1'b0;
            rgb_s1_q    <= '0;
            pix_rgb_q   <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_sof_q   <= 1'b0;
            pix_eol_q   <= 1'b0;
        end else begin
            error_q <= 1'b0;
            if (!en) begin
                state_q <= ST_SEARCH;
            end else begin
                case (state_q)
                    ST_SEARCH:  if (vs_lead) state_q <= ST_MEASURE;
                    ST_MEASURE: if (vs_lead) state_q <= ST_VERIFY;
                    ST_VERIFY:  if (vs_lead && geom_ok) state_q <= ST_LOCKED;
                    ST_LOCKED: begin
                        if (violation) begin
                            state_q <= ST_VERIFY;
                            error_q <= 1'b1;
                        end
                    end
                    default:    state_q <= ST_SEARCH;
                endcase
            end

            if (load_cand) begin
                cand_w_q  <= meas_w;
                cand_h_q  <= meas_h;
                cand_lt_q <= meas_lt;
            end

            line_clk_q <= hs_lead ? CNT_WIDTH'(1)
                        : ((line_clk_q == CNT_MAX) ? line_clk_q : line_clk_q + CNT_WIDTH'(1));
            if (hs_lead) begin
                x_cnt_q <= de_s1 ? POS_WIDTH'(1) : '0;
            end else if (de_s1 && (x_cnt_q != POS_MAX)) begin
                x_cnt_q <= x_cnt_q + POS_WIDTH'(1);
            end
            y_cnt_q <= vs_lead ? '0 : meas_h;
            if (de_fall) last_w_q  <= x_cnt_q;
            if (hs_lead) last_lt_q <= line_clk_q;

            rgb_s1_q    <= {in_red, in_green, in_blue};
            pix_rgb_q   <= rgb_s1_q;
            pix_x_q     <= x_now;
            pix_y_q     <= y_now;
            pix_valid_q <= valid_d;
            pix_sof_q   <= valid_d && (x_now == '0) && (y_now == '0);
            pix_eol_q   <= valid_d && (x_now == cand_w_q - POS_WIDTH'(1));
        end
    end

    assign pix_valid    = pix_valid_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_red      = pix_rgb_q[23:16];
    assign pix_green    = pix_rgb_q[15:8];
    assign pix_blue     = pix_rgb_q[7:0];
    assign pix_sof      = pix_sof_q;
    assign pix_eol      = pix_eol_q;
    assign locked       = (state_q == ST_LOCKED);
    assign frame_width  = cand_w_q;
    assign frame_height = cand_h_q;
    assign line_total   = cand_lt_q;
    assign error        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_video_capture_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_capture_decoder
// Description : Scoreboard bench for video_capture_decoder on a small raster.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_video_capture_decoder;

    localparam int W = 16, H = 6, LT = 40, V = 10, ROW0 = 3, DE0 = 8;

    logic clk = 1'b0;
    logic rst, en, hs_b, vs_b, de_b;
    logic [7:0] r_b, g_b, b_b;

    always #5 clk = ~clk;

    logic       pv1, sof1, eol1, lk1, er1, pv2, sof2, eol2, lk2, er2;
    logic [9:0] px1, py1, fw1, fh1, px2, py2, fw2, fh2;
    logic [7:0] pr1, pg1, pb1, pr2, pg2, pb2;
    logic [11:0] lt1, lt2;

    video_capture_decoder #(.SYNC_ACTIVE_LOW(1'b1)) dut (
        .disp_clk(clk), .reset(rst), .en(en),
        .in_hsync(~hs_b), .in_vsync(~vs_b), .in_de(de_b),
        .in_red(r_b), .in_green(g_b), .in_blue(b_b),
        .pix_valid(pv1), .pix_x(px1), .pix_y(py1),
        .pix_red(pr1), .pix_green(pg1), .pix_blue(pb1),
        .pix_sof(sof1), .pix_eol(eol1), .locked(lk1),
        .frame_width(fw1), .frame_height(fh1), .line_total(lt1), .error(er1)
    );

    video_capture_decoder #(.SYNC_ACTIVE_LOW(1'b0)) dut_pol (
        .disp_clk(clk), .reset(rst), .en(en),
        .in_hsync(hs_b), .in_vsync(vs_b), .in_de(de_b),
        .in_red(r_b), .in_green(g_b), .in_blue(b_b),
        .pix_valid(pv2), .pix_x(px2), .pix_y(py2),
        .pix_red(pr2), .pix_green(pg2), .pix_blue(pb2),
        .pix_sof(sof2), .pix_eol(eol2), .locked(lk2),
        .frame_width(fw2), .frame_height(fh2), .line_total(lt2), .error(er2)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0, failures = 0, vcnt = 0, err_cnt = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected pixel per qualified output cycle.
    initial begin
        pix_t a, e;
        logic err_prev, lk_prev;
        err_prev = 1'b0;
        lk_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (pv1) begin
                checks++;
                a = '{x: px1, y: py1, rgb: {pr1, pg1, pb1}, sof: sof1, eol: eol1};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pixel_unexpected got=%h exp=none", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL pixel got=%h exp=%h", a, e);
                    end
                    vcnt++;
                end
            end
            if (er1) begin
                err_cnt++;
                checks++;
                if (lk1 || !lk_prev || err_prev) begin
                    failures++;
                    $display("FAIL error_shape got lk=%0b lk_prev=%0b err_prev=%0b exp 0/1/0",
                             lk1, lk_prev, err_prev);
                end
            end
            err_prev = er1;
            lk_prev  = lk1;
        end
    end

    task automatic drive_frame(input bit exp_valid, input int short_row, input int stop_line,
                               input int en_line, input bit lock_rise);
        bit   lost, de;
        int   row, len, x;
        pix_t e;
        lost = 1'b0;
        for (int l = 0; l < V; l++) begin
            if (l == stop_line) return;
            for (int c = 0; c < LT; c++) begin
                row  = l - ROW0;
                len  = (row == short_row) ? W - 1 : W;
                de   = (l >= ROW0) && (l < ROW0 + H) && (c >= DE0) && (c < DE0 + len);
                x    = c - DE0;
                hs_b = (c < 4);
                vs_b = (l < 2);
                de_b = de;
                r_b  = x[7:0];
                g_b  = row[7:0];
                b_b  = 8'hA5;
                en   = !((l == en_line) && (c >= 26) && (c < 36));
                if (!en) lost = 1'b1;
                if (exp_valid && !lost && de) begin
                    e = '{x: x[9:0], y: row[9:0], rgb: {x[7:0], row[7:0], 8'hA5},
                          sof: (x == 0) && (row == 0), eol: (x == W - 1)};
                    exp_q.push_back(e);
                end
                if (de && (row == short_row) && (x == len - 1)) lost = 1'b1;
                @(negedge clk);
                if (lock_rise && l == 0 && c == 0) chk("lock_before_vs3", lk1, 0);
                if (lock_rise && l == 0 && c == 1) chk("lock_at_vs3", lk1, 1);
                if (!en) chk("en_low_outputs", {pv1, lk1, er1, pv2, lk2, er2}, 0);
            end
        end
    endtask

    task automatic chk_geometry(input string name);
        chk(name, {lk1, fw1, fh1, lt1}, {1'b1, 10'(W), 10'(H), 12'(LT)});
        chk({name, "_pol"}, {lk2, fw2, fh2, lt2}, {1'b1, 10'(W), 10'(H), 12'(LT)});
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {pv1, px1, py1, pr1, pg1, pb1, sof1, eol1, lk1, fw1, fh1, lt1, er1}, 0);
        chk({name, "_pol"}, {pv2, px2, py2, pr2, pg2, pb2, sof2, eol2, lk2, fw2, fh2, lt2, er2}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=expired exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; hs_b = 1'b0; vs_b = 1'b0; de_b = 1'b0;
        r_b = 8'h00; g_b = 8'h00; b_b = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        rst = 1'b0;

        // Lock acquisition
        drive_frame(0, -1, -1, -1, 0);
        chk("lock_f1", lk1, 0);
        drive_frame(0, -1, -1, -1, 0);
        chk("lock_f2", {lk1, fw1, fh1, lt1}, {1'b0, 10'(W), 10'(H), 12'(LT)});
        vcnt = 0;
        drive_frame(1, -1, -1, -1, 1);
        chk_geometry("geometry_locked");
        chk("valid_count_f3", vcnt, W * H);
        vcnt = 0;
        drive_frame(1, -1, -1, -1, 0);
        chk("valid_count_f4", vcnt, W * H);
        chk("queue_empty_f4", exp_q.size(), 0);

        // Width violation on active row 2
        vcnt = 0;
        drive_frame(1, 2, -1, -1, 0);
        chk("err_after_short", {lk1, 8'(err_cnt)}, {1'b0, 8'd1});
        chk("valid_count_short", vcnt, 2 * W + W - 1);
        drive_frame(0, -1, -1, -1, 0);
        chk("lock_after_bad_vs1", lk1, 0);
        drive_frame(1, -1, -1, -1, 0);
        chk_geometry("relock_after_width");

        // Reset in the middle of a frame
        drive_frame(1, -1, 5, -1, 0);
        hs_b = 1'b0; vs_b = 1'b0; de_b = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        chk_all_zero("reset_midframe");
        chk("queue_empty_reset", exp_q.size(), 0);
        rst = 1'b0;
        drive_frame(0, -1, -1, -1, 0);
        drive_frame(0, -1, -1, -1, 0);
        chk("lock_after_reset_f2", lk1, 0);
        drive_frame(1, -1, -1, -1, 1);
        chk_geometry("relock_after_reset");

        // Enable dropped for 10 cycles while locked
        drive_frame(1, -1, -1, 5, 0);
        chk("en_no_error", {lk1, 8'(err_cnt)}, {1'b0, 8'd1});
        drive_frame(0, -1, -1, -1, 0);
        drive_frame(0, -1, -1, -1, 0);
        chk("lock_after_en_f2", lk1, 0);
        drive_frame(1, -1, -1, -1, 1);
        chk_geometry("relock_after_en");

        repeat (4) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_err_count", err_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
